// File: rtl/em_pp_accum_pkg.sv
// Shared widths, FSM encodings and helpers for the Booth partial-product accumulator.
package em_pp_accum_pkg;

    localparam int PP_W  = 18;
    localparam int N_PP  = 8;
    localparam int ACC_W = 40;
    localparam int IDX_W = $clog2(N_PP);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ACCUM = 2'b01,
        ST_FIN   = 2'b10
    } state_e;

    // Signed add overflow: operands agree in sign, result does not.
    function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/em_pp_align.sv
// Weights one partial product: sign-extend, apply the negate +1, shift by 4^idx.
module em_pp_align
    import em_pp_accum_pkg::*;
(
    input  logic [PP_W-1:0]  pp_i,
    input  logic             pp_neg_i,
    input  logic [IDX_W-1:0] idx_i,
    output logic [ACC_W-1:0] addend_o
);

    logic [ACC_W-1:0] ext;
    logic [IDX_W:0]   shamt;

    always_comb begin
        ext      = {{(ACC_W-PP_W){pp_i[PP_W-1]}}, pp_i} + {{(ACC_W-1){1'b0}}, pp_neg_i};
        shamt    = {idx_i, 1'b0};
        addend_o = ext << shamt;
    end

endmodule

// File: rtl/em_pp_accum.sv
// Sequential partial-product accumulator with optional MAC accumulate and sticky overflow.
//   state    | meaning
//   ST_IDLE  | waiting for start; pp inputs ignored
//   ST_ACCUM | accepting N_PP partial products, summing into psum
//   ST_FIN   | folding psum into acc, updating overflow
module em_pp_accum
    import em_pp_accum_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             acc_clr_i,
    input  logic             pp_valid_i,
    input  logic [PP_W-1:0]  pp_i,
    input  logic             pp_neg_i,
    output logic             pp_ready_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [ACC_W-1:0] prod_o,
    output logic             ovf_o
);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [ACC_W-1:0]   psum_q, psum_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               ovf_q, ovf_d;
    logic               clr_q, clr_d;
    logic               done_q, done_d;
    logic [ACC_W-1:0]   addend;
    logic [ACC_W-1:0]   fin_base;
    logic [ACC_W-1:0]   fin_sum;

    em_pp_align u_align (
        .pp_i     (pp_i),
        .pp_neg_i (pp_neg_i),
        .idx_i    (idx_q),
        .addend_o (addend)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        psum_d     = psum_q;
        acc_d      = acc_q;
        ovf_d      = ovf_q;
        clr_d      = clr_q;
        done_d     = 1'b0;
        pp_ready_o = 1'b0;
        busy_o     = 1'b0;
        fin_base   = clr_q ? '0 : acc_q;
        fin_sum    = fin_base + psum_q;

        case (state_q)
            ST_IDLE: begin
                // The done cycle is still IDLE; holding off start there keeps
                // a new operation from overlapping the result handoff.
                if (start_i && !done_q) begin
                    clr_d   = acc_clr_i;
                    psum_d  = '0;
                    idx_d   = '0;
                    state_d = ST_ACCUM;
                    if (acc_clr_i) begin
                        ovf_d = 1'b0;
                    end
                end
            end
            ST_ACCUM: begin
                pp_ready_o = 1'b1;
                busy_o     = 1'b1;
                if (pp_valid_i) begin
                    psum_d = psum_q + addend;
                    if (idx_q == IDX_W'(N_PP-1)) begin
                        state_d = ST_FIN;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_FIN: begin
                busy_o  = 1'b1;
                acc_d   = fin_sum;
                done_d  = 1'b1;
                state_d = ST_IDLE;
                if (add_ovf(fin_base[ACC_W-1], psum_q[ACC_W-1], fin_sum[ACC_W-1])) begin
                    ovf_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            psum_q  <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            clr_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            psum_q  <= psum_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            clr_q   <= clr_d;
            done_q  <= done_d;
        end
    end

    assign done_o = done_q;
    assign prod_o = acc_q;
    assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_em_pp_accum.sv
// Self-checking bench for em_pp_accum: directed cases plus randomized MACs against an arithmetic model.
module tb_em_pp_accum;

    localparam int N = 8;
    localparam longint TWO39 = longint'(1) << 39;
    localparam longint TWO40 = longint'(1) << 40;

    logic        clk = 1'b0;
    logic        rst, start, acc_clr, pp_valid, pp_neg;
    logic [17:0] pp;
    logic        pp_ready, busy, done, ovf;
    logic [39:0] prod;

    int          errors = 0;
    int          checks = 0;
    logic [17:0] cur_pp  [N];
    logic        cur_neg [N];
    logic [39:0] m_acc = '0;
    logic        m_ovf = 1'b0;

    em_pp_accum dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .acc_clr_i  (acc_clr),
        .pp_valid_i (pp_valid),
        .pp_i       (pp),
        .pp_neg_i   (pp_neg),
        .pp_ready_o (pp_ready),
        .busy_o     (busy),
        .done_o     (done),
        .prod_o     (prod),
        .ovf_o      (ovf)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic longint to_signed(input logic [39:0] u);
        longint r;
        r = longint'(u);
        if (r >= TWO39) r -= TWO40;
        return r;
    endfunction

    // Product = sum over k of (signed pp_k + neg_k) * 4^k.
    function automatic longint model_prod();
        longint p, v;
        p = 0;
        for (int i = 0; i < N; i++) begin
            v = longint'(cur_pp[i]);
            if (v >= (longint'(1) << 17)) v -= (longint'(1) << 18);
            v += longint'(cur_neg[i]);
            p += v * (longint'(1) << (2 * i));
        end
        return p;
    endfunction

    task automatic set_zero();
        for (int i = 0; i < N; i++) begin
            cur_pp[i]  = '0;
            cur_neg[i] = 1'b0;
        end
    endtask

    task automatic set_t1();
        set_zero();
        cur_pp[0] = 18'd3;
        cur_pp[1] = 18'd3;
    endtask

    task automatic set_t2();
        set_zero();
        cur_pp[0]  = 18'h3FFFC;
        cur_neg[0] = 1'b1;
    endtask

    // Any value below 2^31 split across digit 0 and digit 7.
    task automatic set_val(input logic [30:0] v);
        set_zero();
        cur_pp[0] = {4'b0, v[13:0]};
        cur_pp[7] = {1'b0, v[30:14]};
    endtask

    task automatic run_op(input bit clr, input int nstall, input bit poke);
        longint      p, base, s;
        logic [39:0] e_acc;
        bit          e_ovf, got;
        int          cyc, fed, stl, used;
        p     = model_prod();
        base  = clr ? 0 : to_signed(m_acc);
        s     = base + p;
        e_ovf = clr ? 1'b0 : m_ovf;
        if (s >= TWO39 || s < -TWO39) e_ovf = 1'b1;
        e_acc = s[39:0];

        @(negedge clk);
        start = 1'b1; acc_clr = clr; pp_valid = 1'b1; pp = 18'($urandom); pp_neg = 1'b1;
        @(negedge clk);
        start = poke; pp_valid = 1'b0; cyc = 1;
        chk("busy_accum", 64'(busy), 64'd1);
        chk("ready_accum", 64'(pp_ready), 64'd1);
        fed = 0; stl = nstall; used = 0;
        while (fed < N) begin
            if (stl > 0 && ($urandom_range(1, 0) == 1 || fed >= 5)) begin
                pp_valid = 1'b0; pp = 18'($urandom); pp_neg = 1'($urandom);
                stl--; used++;
            end else begin
                pp_valid = 1'b1; pp = cur_pp[fed]; pp_neg = cur_neg[fed];
                fed++;
            end
            @(negedge clk);
            cyc++;
        end
        pp_valid = 1'b0;
        got = 1'b0;
        while (!got && cyc < 40) begin
            if (done === 1'b1) got = 1'b1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        chk("done_seen", 64'(got), 64'd1);
        chk("latency", 64'(cyc), 64'(10 + used));
        chk("prod", 64'(prod), 64'(e_acc));
        chk("ovf", 64'(ovf), 64'(e_ovf));
        chk("busy_at_done", 64'(busy), 64'd0);
        m_acc = e_acc;
        m_ovf = e_ovf;
        @(negedge clk);
        chk("done_one_cycle", 64'(done), 64'd0);
        chk("idle_after_done", 64'(busy), 64'd0);
        chk("prod_hold", 64'(prod), 64'(e_acc));
        start = 1'b0;
    endtask

    task automatic preload_to_max();
        set_val(31'h7FFFFFFF);
        run_op(1'b1, 0, 1'b0);
        for (int k = 1; k < 256; k++) run_op(1'b0, 0, 1'b0);
        set_val(31'd255);
        run_op(1'b0, 0, 1'b0);
        chk("preload_max", 64'(prod), 64'h7FFFFFFFFF);
        chk("preload_ovf", 64'(ovf), 64'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; acc_clr = 1'b0; pp_valid = 1'b0; pp = '0; pp_neg = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_prod", 64'(prod), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ready", 64'(pp_ready), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", 64'(pp_ready), 64'd0);

        set_t1();  run_op(1'b1, 0, 1'b0);
        chk("t1_prod", 64'(prod), 64'd15);
        chk("t1_ovf", 64'(ovf), 64'd0);
        set_t1();  run_op(1'b0, 0, 1'b0);
        chk("t3_acc30", 64'(prod), 64'd30);
        set_t2();  run_op(1'b0, 0, 1'b0);
        chk("t3_acc27", 64'(prod), 64'd27);
        set_t2();  run_op(1'b1, 0, 1'b0);
        chk("t2_neg3", 64'(prod), 64'hFFFFFFFFFD);
        set_t1();  run_op(1'b1, 3, 1'b1);
        chk("t4_stall_prod", 64'(prod), 64'd15);

        preload_to_max();
        set_val(31'd1); run_op(1'b0, 0, 1'b0);
        chk("t5_wrap", 64'(prod), 64'h8000000000);
        chk("t5_ovf_set", 64'(ovf), 64'd1);
        set_t1();  run_op(1'b0, 0, 1'b0);
        chk("t5_ovf_sticky", 64'(ovf), 64'd1);

        set_t1();
        @(negedge clk);
        start = 1'b1; acc_clr = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pp_valid = 1'b1; pp = cur_pp[i]; pp_neg = cur_neg[i];
            @(negedge clk);
        end
        rst = 1'b1; pp_valid = 1'b0;
        @(negedge clk);
        chk("t6_prod", 64'(prod), 64'd0);
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_ovf", 64'(ovf), 64'd0);
        chk("t6_done", 64'(done), 64'd0);
        rst = 1'b0; m_acc = '0; m_ovf = 1'b0;
        @(negedge clk);
        chk("t6_no_done", 64'(done), 64'd0);
        chk("t6_idle", 64'(busy), 64'd0);
        set_t1();  run_op(1'b1, 0, 1'b0);
        chk("t6_fresh", 64'(prod), 64'd15);

        preload_to_max();
        set_val(31'd1); run_op(1'b0, 0, 1'b0);
        chk("t5b_ovf_set", 64'(ovf), 64'd1);
        set_t1();  run_op(1'b1, 0, 1'b0);
        chk("t5b_ovf_clr", 64'(ovf), 64'd0);
        chk("t5b_prod", 64'(prod), 64'd15);

        for (int r = 0; r < 24; r++) begin
            for (int i = 0; i < N; i++) begin
                cur_pp[i]  = 18'($urandom);
                cur_neg[i] = 1'($urandom);
            end
            run_op((r == 0) ? 1'b1 : 1'($urandom), int'($urandom_range(3, 0)), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
